// File: rtl/bnn_seq_engine_if.sv
// bnn_seq_engine_if: handshake bundle between a feature source / result
// consumer and the bnn_seq_engine.
//   features   : FEAT_BITS*FEAT_CNT packed unsigned features, feature i at
//                [i*FEAT_BITS +: FEAT_BITS]
//   in_valid   : source has a sample on features
//   in_ready   : engine can accept a sample
//   prediction : winning class index
//   out_valid  : prediction valid
//   out_ready  : consumer takes the prediction
//   busy       : engine is evaluating a layer
//   max_score  : winning score (only when BNN_SCORE_OUT_EN is defined)
// Modports: master = source/consumer side, slave = engine side.
interface bnn_seq_engine_if #(
  parameter int FEAT_CNT  = 128,
  parameter int FEAT_BITS = 4,
  parameter int CLASS_CNT = 6
`ifdef BNN_SCORE_OUT_EN
  ,
  parameter int HIDDEN_CNT = 40
`endif
);
  logic [FEAT_BITS*FEAT_CNT-1:0] features;
  logic                          in_valid;
  logic                          in_ready;
  logic [$clog2(CLASS_CNT)-1:0]  prediction;
  logic                          out_valid;
  logic                          out_ready;
  logic                          busy;
`ifdef BNN_SCORE_OUT_EN
  logic [$clog2(HIDDEN_CNT+1)-1:0] max_score;

  modport master (output features, in_valid, out_ready,
                  input  in_ready, prediction, out_valid, busy, max_score);
  modport slave  (input  features, in_valid, out_ready,
                  output in_ready, prediction, out_valid, busy, max_score);
`else
  modport master (output features, in_valid, out_ready,
                  input  in_ready, prediction, out_valid, busy);
  modport slave  (input  features, in_valid, out_ready,
                  output in_ready, prediction, out_valid, busy);
`endif
endinterface

// File: rtl/bnn_seq_engine.sv
// bnn_seq_engine: sequential two-layer binarised classifier.
//   Layer 1: sum_j = sum_i (w1[j][i] ? f_i : FMAX-f_i), h_j = sum_j >= t1[j].
//   Layer 2: score_c = popcount(~(w2[c] ^ h)); prediction = argmax, lowest
//   index wins ties. PAR_HID hidden neurons and PAR_CLS class scores are
//   evaluated per clock.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : bnn_seq_engine_if slave (features/in_valid/in_ready in,
//              prediction/out_valid/out_ready out, busy)
// ROM contents are packed parameters:
//   W1_INIT row j at [j*FEAT_CNT +: FEAT_CNT], bit i = weight(feature i, hidden j)
//   T1_INIT row j at [j*SUM1_BITS +: SUM1_BITS]
//   W2_INIT row c at [c*HIDDEN_CNT +: HIDDEN_CNT]
// Optional macro BNN_SCORE_OUT_EN adds the registered max_score output.
module bnn_seq_engine #(
  parameter int FEAT_CNT   = 128,
  parameter int FEAT_BITS  = 4,
  parameter int HIDDEN_CNT = 40,
  parameter int CLASS_CNT  = 6,
  parameter int PAR_HID    = 1,
  parameter int PAR_CLS    = 1,
  parameter logic [HIDDEN_CNT*FEAT_CNT-1:0] W1_INIT = '0,
  parameter logic [HIDDEN_CNT*$clog2(FEAT_CNT*(2**FEAT_BITS-1)+1)-1:0] T1_INIT = '0,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W2_INIT = '0
) (
  input logic             clk,
  input logic             rst,
  bnn_seq_engine_if.slave bus
);
  localparam int FMAX       = 2**FEAT_BITS - 1;
  localparam int SUM1_BITS  = $clog2(FEAT_CNT*FMAX + 1);
  localparam int SCORE_BITS = $clog2(HIDDEN_CNT + 1);
  localparam int IDX_BITS   = $clog2(CLASS_CNT);
  localparam int FEAT_W     = FEAT_BITS*FEAT_CNT;
  localparam int H_STEPS    = (HIDDEN_CNT + PAR_HID - 1) / PAR_HID;
  localparam int C_STEPS    = (CLASS_CNT + PAR_CLS - 1) / PAR_CLS;
  localparam int MAX_STEPS  = (H_STEPS > C_STEPS) ? H_STEPS : C_STEPS;
  localparam int STEP_W     = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HIDDEN = 2'd1,
    CLASS  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                  state_r, state_n_s;
  logic                    accept_s, last_step_s;
  logic                    in_ready_r, busy_r, out_valid_r;
  logic [FEAT_W-1:0]       feat_r;
  logic [HIDDEN_CNT-1:0]   hid_r, hid_n_s;
  logic [STEP_W-1:0]       step_r;
  logic [SCORE_BITS-1:0]   max_r, max_n_s, score_s;
  logic [IDX_BITS-1:0]     idx_r, idx_n_s, pred_r;
  logic                    neuron_s;
  int                      lane_h_s, lane_c_s;
`ifdef BNN_SCORE_OUT_EN
  logic [SCORE_BITS-1:0]   max_score_r;
`endif

  // FMAX - f equals ~f for an unsigned FEAT_BITS value, so no subtractor.
  function automatic logic [SUM1_BITS-1:0] layer1_sum(input logic [FEAT_W-1:0] f,
                                                      input logic [FEAT_CNT-1:0] w);
    logic [SUM1_BITS-1:0] acc;
    logic [FEAT_BITS-1:0] fi;
    acc = '0;
    for (int i = 0; i < FEAT_CNT; i++) begin
      fi  = f[i*FEAT_BITS +: FEAT_BITS];
      acc = acc + SUM1_BITS'(w[i] ? fi : ~fi);
    end
    return acc;
  endfunction

  function automatic logic [SCORE_BITS-1:0] popcount(input logic [HIDDEN_CNT-1:0] v);
    logic [SCORE_BITS-1:0] acc;
    acc = '0;
    for (int i = 0; i < HIDDEN_CNT; i++) begin
      acc = acc + SCORE_BITS'(v[i]);
    end
    return acc;
  endfunction

  // Next-state and handshake decode.
  always_comb begin
    state_n_s   = state_r;
    accept_s    = 1'b0;
    last_step_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid && in_ready_r) begin
          accept_s  = 1'b1;
          state_n_s = HIDDEN;
        end else begin
          state_n_s = IDLE;
        end
      end
      HIDDEN: begin
        if (step_r == STEP_W'(H_STEPS - 1)) begin
          last_step_s = 1'b1;
          state_n_s   = CLASS;
        end else begin
          state_n_s = HIDDEN;
        end
      end
      CLASS: begin
        if (step_r == STEP_W'(C_STEPS - 1)) begin
          last_step_s = 1'b1;
          state_n_s   = DONE;
        end else begin
          state_n_s = CLASS;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = DONE;
        end
      end
      default: state_n_s = IDLE;
    endcase
  end

  // State register; handshake outputs are registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      in_ready_r  <= (state_n_s == IDLE);
      busy_r      <= (state_n_s == HIDDEN) || (state_n_s == CLASS);
      out_valid_r <= (state_n_s == DONE);
    end
  end

  // Hidden lanes of the current step; lanes past HIDDEN_CNT leave hid untouched.
  always_comb begin
    hid_n_s  = hid_r;
    lane_h_s = 0;
    neuron_s = 1'b0;
    for (int p = 0; p < PAR_HID; p++) begin
      lane_h_s = int'(step_r) * PAR_HID + p;
      if (lane_h_s < HIDDEN_CNT) begin
        neuron_s = layer1_sum(feat_r, FEAT_CNT'(W1_INIT >> (lane_h_s * FEAT_CNT)))
                   >= SUM1_BITS'(T1_INIT >> (lane_h_s * SUM1_BITS));
        hid_n_s  = hid_n_s | (HIDDEN_CNT'(neuron_s) << lane_h_s);
      end else begin
        hid_n_s = hid_n_s;
      end
    end
  end

  // Class lanes folded in ascending index order with a strict compare, so the
  // lowest index keeps a tie both within a step and across steps.
  always_comb begin
    max_n_s  = max_r;
    idx_n_s  = idx_r;
    score_s  = '0;
    lane_c_s = 0;
    for (int p = 0; p < PAR_CLS; p++) begin
      lane_c_s = int'(step_r) * PAR_CLS + p;
      if (lane_c_s < CLASS_CNT) begin
        score_s = popcount(~(HIDDEN_CNT'(W2_INIT >> (lane_c_s * HIDDEN_CNT)) ^ hid_r));
        if (score_s > max_n_s) begin
          max_n_s = score_s;
          idx_n_s = IDX_BITS'(lane_c_s);
        end else begin
          max_n_s = max_n_s;
        end
      end else begin
        max_n_s = max_n_s;
      end
    end
  end

  // Datapath registers: feature latch, hidden vector, step counter, running max.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feat_r <= '0;
      hid_r  <= '0;
      step_r <= '0;
      max_r  <= '0;
      idx_r  <= '0;
      pred_r <= '0;
`ifdef BNN_SCORE_OUT_EN
      max_score_r <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            feat_r <= bus.features;
            hid_r  <= '0;
            step_r <= '0;
            max_r  <= '0;
            idx_r  <= '0;
          end
        end
        HIDDEN: begin
          hid_r  <= hid_n_s;
          step_r <= last_step_s ? '0 : step_r + STEP_W'(1);
        end
        CLASS: begin
          max_r  <= max_n_s;
          idx_r  <= idx_n_s;
          step_r <= last_step_s ? '0 : step_r + STEP_W'(1);
          if (last_step_s) begin
            pred_r <= idx_n_s;
`ifdef BNN_SCORE_OUT_EN
            max_score_r <= max_n_s;
`endif
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.busy       = busy_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.prediction = pred_r;
`ifdef BNN_SCORE_OUT_EN
  assign bus.max_score  = max_score_r;
`endif

endmodule
